// File: rtl/fft_in_streamer.sv
// Sample feeder for the 16-point FFT core: valid/ready upstream, small FIFO, stall-aware push.
// Optional zero padding of short frames when FFT_IN_STREAMER_ZERO_PAD_EN is defined.
module fft_in_streamer #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned FRAME_LEN = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_real,
  input  logic [15:0] s_imag,
  input  logic        s_last,
  output logic        in_push,
  output logic [15:0] in_real,
  output logic [15:0] in_imag,
  input  logic        in_stall,
  output logic [3:0]  beat_idx,
  output logic [7:0]  frame_cnt,
  output logic        frame_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [3:0]  LAST_BEAT = 4'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    ST_STREAM = 2'd0,
    ST_WAIT   = 2'd1
`ifdef FFT_IN_STREAMER_ZERO_PAD_EN
    , ST_PAD  = 2'd2
`endif
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [3:0]      beat_q, beat_d;
  logic [7:0]      frame_q, frame_d;
  logic            err_q, err_d;

  logic [15:0]     mem_real_q [DEPTH];
  logic [15:0]     mem_real_d [DEPTH];
  logic [15:0]     mem_imag_q [DEPTH];
  logic [15:0]     mem_imag_d [DEPTH];
  logic            mem_last_q [DEPTH];
  logic            mem_last_d [DEPTH];

  logic            fifo_nonempty;
  logic            head_valid;
  logic            head_last;
  logic            accept;
  logic            xfer;
  logic            deq;

  always_comb begin
    fifo_nonempty = (count_q != '0);
    head_valid    = (state_q == ST_STREAM) && fifo_nonempty;
    head_last     = mem_last_q[rd_ptr_q];

    s_ready = !reset && (count_q < CW'(DEPTH));
`ifdef FFT_IN_STREAMER_ZERO_PAD_EN
    in_push = head_valid || (state_q == ST_PAD);
`else
    in_push = head_valid;
`endif
    // Outside a live FIFO transfer (WAIT, PAD, empty) the data bus reads zero.
    in_real = head_valid ? mem_real_q[rd_ptr_q] : '0;
    in_imag = head_valid ? mem_imag_q[rd_ptr_q] : '0;

    beat_idx  = beat_q;
    frame_cnt = frame_q;
    frame_err = err_q;

    accept = s_valid && s_ready;
    xfer   = in_push && !in_stall;
    deq    = xfer && (state_q == ST_STREAM);
  end

  always_comb begin
    mem_real_d = mem_real_q;
    mem_imag_d = mem_imag_q;
    mem_last_d = mem_last_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (accept) begin
      mem_real_d[wr_ptr_q] = s_real;
      mem_imag_d[wr_ptr_q] = s_imag;
      mem_last_d[wr_ptr_q] = s_last;
      wr_ptr_d             = wr_ptr_q + AW'(1);
    end
    if (deq) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(accept) - CW'(deq);
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    frame_d = frame_q;
    err_d   = err_q;
    case (state_q)
      ST_STREAM: begin
        if (xfer) begin
          if (beat_q == LAST_BEAT) begin
            if (!head_last) err_d = 1'b1;
            beat_d  = '0;
            frame_d = frame_q + 8'd1;
            state_d = ST_WAIT;
          end else begin
            beat_d = beat_q + 4'd1;
            if (head_last) begin
`ifdef FFT_IN_STREAMER_ZERO_PAD_EN
              state_d = ST_PAD;
`else
              err_d = 1'b1;
`endif
            end
          end
        end
      end
      // Hold off the next frame until the core has shown it is busy closing this one.
      ST_WAIT: begin
        if (in_stall) state_d = ST_STREAM;
      end
`ifdef FFT_IN_STREAMER_ZERO_PAD_EN
      ST_PAD: begin
        if (xfer) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            frame_d = frame_q + 8'd1;
            state_d = ST_WAIT;
          end else begin
            beat_d = beat_q + 4'd1;
          end
        end
      end
`endif
      default: state_d = ST_STREAM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_STREAM;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      beat_q   <= '0;
      frame_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      beat_q   <= beat_d;
      frame_q  <= frame_d;
      err_q    <= err_d;
    end
  end

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    mem_real_q <= mem_real_d;
    mem_imag_q <= mem_imag_d;
    mem_last_q <= mem_last_d;
  end

endmodule
